// File: rtl/riscy_pkg.sv
// Shared RV32I decode definitions: ALU op encoding, opcode/funct constants and
// a pure decode function used by the issue stage.
package riscy_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  typedef struct packed {
    logic      legal;
    logic      is_r;   // opcode is OP_REG, so rs2 takes part in hazard check
    alu_ctrl_e ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [11:0] imm;
  } decoded_t;

  function automatic decoded_t decode(input logic [31:0] instr);
    decoded_t   d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op      = instr[6:0];
    f3      = instr[14:12];
    f7      = instr[31:25];
    d       = '0;
    d.ctrl  = ALU_ADD;
    d.rd    = instr[11:7];
    d.rs1   = instr[19:15];
    d.rs2   = instr[24:20];
    d.imm   = instr[31:20];
    d.is_r  = (op == OP_REG);
    if (op == OP_REG) begin
      case (f3)
        F3_ADD: begin
          d.legal = (f7 == F7_BASE) || (f7 == F7_SUB);
          d.ctrl  = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        end
        F3_SLT: begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_SLT; end
        F3_OR:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_OR;  end
        F3_AND: begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_AND; end
        default: d.legal = 1'b0;
      endcase
    end else if (op == OP_IMM) begin
      case (f3)
        F3_ADD: begin d.legal = 1'b1; d.ctrl = ALU_ADD; end
        F3_SLT: begin d.legal = 1'b1; d.ctrl = ALU_SLT; end
        F3_OR:  begin d.legal = 1'b1; d.ctrl = ALU_OR;  end
        F3_AND: begin d.legal = 1'b1; d.ctrl = ALU_AND; end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch-side, issue-side and writeback signals of the decode/issue stage.
interface decode_issue_if #(parameter int XLEN = 32);
  import riscy_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1;
  logic [XLEN-1:0] out_rs2;
  alu_ctrl_e       out_ctrl;
  logic [4:0]      out_rd;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_rs1, out_rs2, out_ctrl, out_rd, illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_rs1, out_rs2, out_ctrl, out_rd, illegal
  );
endinterface

// File: rtl/decode_issue_regfile.sv
// Architectural register file: two async reads with write-through bypass,
// one synchronous write, x0 hardwired to zero. Contents are not reset.
module decode_issue_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != '0)) r_mem[i_waddr] <= i_wdata;
  end

  // A read of the register being written this cycle sees the new value.
  always_comb begin
    o_rdata1 = r_mem[i_raddr1];
    o_rdata2 = r_mem[i_raddr2];
    if (i_we && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
    if (i_we && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
    if (i_raddr1 == '0) o_rdata1 = '0;
    if (i_raddr2 == '0) o_rdata2 = '0;
  end

endmodule

// File: rtl/decode_issue.sv
// RV32I decode / operand issue: decodes, reads operands, tracks in-flight
// destinations with a busy-bit scoreboard and holds one registered ALU slot.
module decode_issue
  import riscy_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  decode_issue_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  decoded_t        w_dec;
  logic [XLEN-1:0] w_rdata1, w_rdata2, w_opb;
  logic [NREGS-1:0] r_busy, w_clr, w_set, w_busy_eff;
  logic            w_hazard, w_ready, w_acc, w_load;

  logic            r_valid, r_illegal;
  logic [XLEN-1:0] r_rs1, r_rs2;
  alu_ctrl_e       r_ctrl;
  logic [4:0]      r_rd;

  assign w_dec = decode(bus.in_instr);

  decode_issue_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_addr[AW-1:0]),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (w_dec.rs1[AW-1:0]),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (w_dec.rs2[AW-1:0]),
    .o_rdata2 (w_rdata2)
  );

  // A producer retiring this cycle no longer blocks its consumers.
  assign w_clr      = bus.wb_en ? (NREGS'(1) << bus.wb_addr) : '0;
  assign w_busy_eff = r_busy & ~w_clr;
  assign w_hazard   = w_busy_eff[w_dec.rs1]
                    | (w_dec.is_r & w_busy_eff[w_dec.rs2])
                    | w_busy_eff[w_dec.rd];
  assign w_ready    = !w_hazard && (!r_valid || bus.out_ready);
  assign w_acc      = bus.in_valid && w_ready;
  assign w_load     = w_acc && w_dec.legal;
  assign w_set      = (w_load && (w_dec.rd != 5'd0)) ? (NREGS'(1) << w_dec.rd) : '0;
  assign w_opb      = w_dec.is_r ? w_rdata2 : {{(XLEN-12){w_dec.imm[11]}}, w_dec.imm};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= (w_busy_eff | w_set) & ~NREGS'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_ctrl    <= ALU_ADD;
      r_rd      <= '0;
    end else begin
      r_illegal <= w_acc && !w_dec.legal;
      if (w_load) begin
        r_valid <= 1'b1;
        r_rs1   <= w_rdata1;
        r_rs2   <= w_opb;
        r_ctrl  <= w_dec.ctrl;
        r_rd    <= w_dec.rd;
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_rs1   = r_rs1;
  assign bus.out_rs2   = r_rs2;
  assign bus.out_ctrl  = r_ctrl;
  assign bus.out_rd    = r_rd;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Randomized bench for decode_issue against a mnemonic-level model of the
// register file, busy table and issue slot.
module tb_decode_issue;
  import riscy_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_issue_if #(.XLEN(32)) bus();
  decode_issue #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [31:0] mregs [32];
  bit          mbusy [32];
  bit          mv, mill;
  logic [31:0] mrs1, mrs2;
  int          mctrl, mrd;

  // op ids: 0 ADD 1 SUB 2 SLT 3 OR 4 AND 5 ADDI 6 SLTI 7 ORI 8 ANDI 9 LOAD 10 MUL-like
  localparam int N_OPS = 11;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(int op, logic [4:0] rd, logic [4:0] rs1,
                                      logic [4:0] rs2, logic [11:0] imm);
    logic [2:0] f3;
    case (op)
      2, 6, 9: f3 = 3'b010;
      3, 7:    f3 = 3'b110;
      4, 8:    f3 = 3'b111;
      default: f3 = 3'b000;
    endcase
    if (op <= 4)  return {(op == 1) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'b0110011};
    if (op == 10) return {7'h01, rs2, rs1, f3, rd, 7'b0110011};
    if (op == 9)  return {imm, rs1, f3, rd, 7'b0000011};
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic int ctl(int op);
    case (op)
      1:       return 1;
      2, 6:    return 5;
      3, 7:    return 3;
      4, 8:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit blocked(int r, bit we, int wa);
    return (r != 0) && mbusy[r] && !(we && wa == r);
  endfunction

  function automatic logic [31:0] rdv(int r, bit we, int wa, logic [31:0] wd);
    if (r == 0) return 32'd0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  task automatic step(input bit iv, input int op, input int rd, input int rs1, input int rs2,
                      input logic [11:0] imm, input bit ordy, input bit we, input int wa,
                      input logic [31:0] wd);
    bit isr, leg, hz, rdy, acc;
    logic [31:0] a, b;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_instr  = enc(op, 5'(rd), 5'(rs1), 5'(rs2), imm);
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_addr   = 5'(wa);
    bus.wb_data   = wd;
    #1;
    isr = (op <= 4) || (op == 10);
    leg = (op <= 8);
    hz  = blocked(rs1, we, wa) || (isr && blocked(rs2, we, wa)) || blocked(rd, we, wa);
    rdy = !hz && (!mv || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    acc = iv && rdy;
    a = rdv(rs1, we, wa, wd);
    b = isr ? rdv(rs2, we, wa, wd) : {{20{imm[11]}}, imm};
    if (acc && leg) begin
      mv = 1; mrs1 = a; mrs2 = b; mctrl = ctl(op); mrd = rd;
    end else if (ordy) mv = 0;
    mill = acc && !leg;
    if (we && wa != 0) begin mregs[wa] = wd; mbusy[wa] = 0; end
    if (acc && leg && rd != 0) mbusy[rd] = 1;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    chk("illegal", 32'(bus.illegal), 32'(mill));
    if (mv) begin
      chk("out_rs1", bus.out_rs1, mrs1);
      chk("out_rs2", bus.out_rs2, mrs2);
      chk("out_ctrl", 32'(bus.out_ctrl), 32'(mctrl));
      chk("out_rd", 32'(bus.out_rd), 32'(mrd));
    end
  endtask

  task automatic idle(input bit we, input int wa, input logic [31:0] wd);
    step(0, 0, 0, 0, 0, 12'd0, 1, we, wa, wd);
  endtask

  initial begin
    int nb;
    int bl [$];
    bus.in_valid = 0; bus.in_instr = '0; bus.out_ready = 0;
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0;
    mv = 0; mill = 0; mrs1 = 0; mrs2 = 0; mctrl = 0; mrd = 0;
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 0; end

    #2;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_rs1", bus.out_rs1, 0);
    chk("rst_rs2", bus.out_rs2, 0);
    chk("rst_ctrl", 32'(bus.out_ctrl), 0);
    chk("rst_rd", 32'(bus.out_rd), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    for (int r = 1; r < 32; r++) idle(1, r, $urandom);

    // register setup and basic decode
    idle(1, 1, 32'd20);
    idle(1, 2, 32'd30);
    step(1, 0, 3, 1, 2, 12'd0, 1, 0, 0, 0);
    chk("add_rs1", bus.out_rs1, 32'd20);
    chk("add_rs2", bus.out_rs2, 32'd30);
    chk("add_rd", 32'(bus.out_rd), 32'd3);
    step(1, 5, 4, 0, 0, 12'hFFB, 1, 0, 0, 0);
    chk("addi_rs2", bus.out_rs2, 32'hFFFF_FFFB);
    step(1, 6, 6, 1, 0, 12'd7, 1, 0, 0, 0);
    chk("slti_ctrl", 32'(bus.out_ctrl), 32'd5);

    // RAW stall on x3, released by the writeback bypass
    step(1, 1, 5, 3, 1, 12'd0, 1, 0, 0, 0);
    step(1, 1, 5, 3, 1, 12'd0, 1, 0, 0, 0);
    step(1, 1, 5, 3, 1, 12'd0, 1, 1, 3, 32'd50);
    chk("raw_rs1", bus.out_rs1, 32'd50);
    chk("raw_ctrl", 32'(bus.out_ctrl), 32'd1);
    idle(1, 4, $urandom); idle(1, 6, $urandom); idle(1, 5, $urandom);

    // back-pressure: slot held three cycles, then consumed and refilled
    step(1, 5, 7, 1, 0, 12'd1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1, 3, 8, 1, 2, 12'd0, 0, 0, 0, 0);
    step(1, 3, 8, 1, 2, 12'd0, 1, 0, 0, 0);
    chk("bp_ctrl", 32'(bus.out_ctrl), 32'd3);
    idle(1, 7, $urandom); idle(1, 8, $urandom);

    // illegal load: pulse, no slot, no busy bit
    step(1, 9, 9, 1, 0, 12'd4, 1, 0, 0, 0);
    chk("ill_pulse", 32'(bus.illegal), 1);
    step(1, 0, 10, 9, 9, 12'd0, 1, 0, 0, 0);
    chk("ill_nobusy", 32'(bus.out_rd), 32'd10);
    idle(1, 10, $urandom);

    // reset while slot full and x3 busy
    step(1, 0, 3, 1, 2, 12'd0, 0, 0, 0, 0);
    step(1, 1, 5, 3, 1, 12'd0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    mv = 0; mill = 0;
    for (int i = 0; i < 32; i++) mbusy[i] = 0;
    #3 rst_n = 1;
    step(1, 1, 5, 3, 1, 12'd0, 1, 0, 0, 0);
    chk("post_rst_rd", 32'(bus.out_rd), 32'd5);
    idle(1, 5, $urandom);

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      bit we;
      int wa;
      bl.delete();
      for (int r = 1; r < 8; r++) if (mbusy[r]) bl.push_back(r);
      we = ($urandom_range(0, 2) == 0);
      nb = bl.size();
      if (nb > 0 && $urandom_range(0, 3) != 0) wa = bl[$urandom_range(0, nb - 1)];
      else wa = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, $urandom_range(0, N_OPS - 1),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           12'($urandom), $urandom_range(0, 3) != 0, we, wa, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
